// File: rtl/icache_fetcher_pkg.sv
// Shared constants for the instruction fetcher: truth values, zero word,
// FSM state encodings and default widths.
package icache_fetcher_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_INDEX_BITS = 6;
  localparam int DEF_LINE_WORDS = 4;

  localparam logic [DEF_DATA_WIDTH-1:0] ZERO_DATA = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Width of the word-select field; a one-word line has no such field.
  function automatic int word_sel_bits(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 0;
  endfunction

endpackage

// File: rtl/icache_fetcher_array.sv
// Direct-mapped line storage: valid bits (reset), tags and data (not reset),
// combinational lookup and a one-word-per-cycle line-fill write port.
module icache_array
  import icache_fetcher_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = 22,
  parameter int CNT_BITS   = 2,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [CNT_BITS-1:0]   rd_word,
  input  logic [TAG_BITS-1:0]   rd_tag,
  output logic                  rd_hit,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  alloc_ena,
  input  logic [INDEX_BITS-1:0] alloc_index,
  input  logic [TAG_BITS-1:0]   alloc_tag,
  input  logic                  wr_ena,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [CNT_BITS-1:0]   wr_word,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  set_valid
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid_reg;
  logic [LINES-1:0]      clr_line;
  logic [LINES-1:0]      set_line;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES][LINE_WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line_dec
      assign clr_line[gi] = alloc_ena && (alloc_index == INDEX_BITS'(gi));
      assign set_line[gi] = wr_ena && set_valid && (wr_index == INDEX_BITS'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= (valid_reg & ~clr_line) | set_line;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_ena) begin
      tag_mem[alloc_index] <= alloc_tag;
    end
    if (wr_ena) begin
      data_mem[wr_index][wr_word] <= wr_data;
    end
  end

  assign rd_hit  = valid_reg[rd_index] && (tag_mem[rd_index] == rd_tag);
  assign rd_data = data_mem[rd_index][rd_word];

endmodule

// File: rtl/icache_fetcher.sv
// Instruction fetcher with a direct-mapped multi-word-line cache and a
// refill/drain FSM. Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_fetcher
  import icache_fetcher_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  in_rollback,
  input  logic [ADDR_WIDTH-1:0] in_normal_pc,
  input  logic [ADDR_WIDTH-1:0] in_rollback_pc,
  input  logic                  in_result_taken,
  input  logic                  in_rs_ok,
  input  logic                  in_rob_ok,
  input  logic                  in_lsqueue_ok,
  output logic                  out_decoder_and_pc_ena,
  output logic                  out_pc_reg_ena,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_decoder_pc,
  output logic                  out_branch_taken,
  output logic                  out_mem_ena,
  output logic [ADDR_WIDTH-1:0] out_address,
`ifdef ICACHE_STATS_EN
  output logic [31:0]           out_hit_count,
  output logic [31:0]           out_miss_count,
`endif
  input  logic                  in_mem_ready,
  input  logic [DATA_WIDTH-1:0] in_mem_inst
);

  localparam int OFF_BITS = word_sel_bits(LINE_WORDS);
  localparam int CNT_BITS = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int LINE_LSB = OFF_BITS + 2;
  localparam int TAG_BITS = ADDR_WIDTH - LINE_LSB - INDEX_BITS;
  localparam logic [CNT_BITS-1:0] LAST_WORD = CNT_BITS'(LINE_WORDS - 1);

  logic [ADDR_WIDTH-1:0] in_pc;
  logic [CNT_BITS-1:0]   pc_word;
  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic                  hit;
  logic [DATA_WIDTH-1:0] rd_data;

  fetch_state_t          state_reg, state_next;
  logic [CNT_BITS-1:0]   cnt_reg, cnt_next;
  logic [INDEX_BITS-1:0] idx_reg, idx_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  mem_ena_reg, mem_ena_next;
  logic                  alloc_ena, wr_ena, set_valid, fill_start;

  assign in_pc    = in_rollback ? in_rollback_pc : in_normal_pc;
  assign pc_index = in_pc[LINE_LSB +: INDEX_BITS];
  assign pc_tag   = in_pc[ADDR_WIDTH-1 -: TAG_BITS];

  generate
    if (OFF_BITS > 0) begin : g_word_sel
      assign pc_word = in_pc[2 +: CNT_BITS];
    end else begin : g_single_word
      assign pc_word = '0;
    end
  endgenerate

  icache_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .CNT_BITS   (CNT_BITS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .rd_index    (pc_index),
    .rd_word     (pc_word),
    .rd_tag      (pc_tag),
    .rd_hit      (hit),
    .rd_data     (rd_data),
    .alloc_ena   (alloc_ena),
    .alloc_index (pc_index),
    .alloc_tag   (pc_tag),
    .wr_ena      (wr_ena),
    .wr_index    (idx_reg),
    .wr_word     (cnt_reg),
    .wr_data     (in_mem_inst),
    .set_valid   (set_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      addr_reg    <= '0;
      mem_ena_reg <= FALSE;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      addr_reg    <= addr_next;
      mem_ena_reg <= mem_ena_next;
    end
  end

  // Every FILL cycle owns exactly one outstanding request, so a rollback
  // without a coincident response must drain it before a new miss may start.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    addr_next    = addr_reg;
    mem_ena_next = FALSE;
    alloc_ena    = FALSE;
    wr_ena       = FALSE;
    set_valid    = FALSE;
    fill_start   = FALSE;
    case (state_reg)
      IDLE: begin
        if (ena && !in_rollback && !hit) begin
          alloc_ena    = TRUE;
          fill_start   = TRUE;
          idx_next     = pc_index;
          cnt_next     = '0;
          addr_next    = {in_pc[ADDR_WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}};
          mem_ena_next = TRUE;
          state_next   = FILL;
        end
      end
      FILL: begin
        if (in_rollback) begin
          state_next = in_mem_ready ? IDLE : DRAIN;
        end else if (in_mem_ready) begin
          wr_ena = TRUE;
          if (cnt_reg == LAST_WORD) begin
            set_valid  = TRUE;
            state_next = IDLE;
          end else begin
            cnt_next     = cnt_reg + CNT_BITS'(1);
            addr_next    = addr_reg + ADDR_WIDTH'(4);
            mem_ena_next = TRUE;
          end
        end
      end
      DRAIN: begin
        if (in_mem_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Invalid or mismatching lines present a zero word rather than stale data.
  assign out_decoder_and_pc_ena = !in_rollback && hit && in_rs_ok && in_rob_ok && in_lsqueue_ok;
  assign out_pc_reg_ena         = out_decoder_and_pc_ena;
  assign out_inst               = hit ? rd_data : DATA_WIDTH'(ZERO_DATA);
  assign out_decoder_pc         = in_pc;
  assign out_branch_taken       = in_result_taken;
  assign out_mem_ena            = mem_ena_reg;
  assign out_address            = addr_reg;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_reg, miss_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (out_decoder_and_pc_ena && (hit_count_reg != '1)) begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
      if (fill_start && (miss_count_reg != '1)) begin
        miss_count_reg <= miss_count_reg + 32'd1;
      end
    end
  end

  assign out_hit_count  = hit_count_reg;
  assign out_miss_count = miss_count_reg;
`else
  logic unused_fill_start;
  assign unused_fill_start = fill_start;
`endif

endmodule

// File: tb/tb_icache_fetcher.sv
// Directed bench for icache_fetcher with a configurable-latency word memory
// whose word at address A is {16'hC0DE, A[15:0]}.
module tb_icache_fetcher;

  logic        clk, rst, ena, in_rollback;
  logic [31:0] in_normal_pc, in_rollback_pc;
  logic        in_result_taken, in_rs_ok, in_rob_ok, in_lsqueue_ok;
  logic        out_decoder_and_pc_ena, out_pc_reg_ena, out_branch_taken, out_mem_ena;
  logic [31:0] out_inst, out_decoder_pc, out_address;
  logic        in_mem_ready;
  logic [31:0] in_mem_inst;
`ifdef ICACHE_STATS_EN
  logic [31:0] out_hit_count, out_miss_count;
`endif

  int total = 0;
  int bad   = 0;
  int mem_lat = 1;
  int n;

  logic        req_p1, req_p2;
  logic [31:0] addr_p1, addr_p2, mem_addr;

  icache_fetcher dut (
    .clk                    (clk),
    .rst                    (rst),
    .ena                    (ena),
    .in_rollback            (in_rollback),
    .in_normal_pc           (in_normal_pc),
    .in_rollback_pc         (in_rollback_pc),
    .in_result_taken        (in_result_taken),
    .in_rs_ok               (in_rs_ok),
    .in_rob_ok              (in_rob_ok),
    .in_lsqueue_ok          (in_lsqueue_ok),
    .out_decoder_and_pc_ena (out_decoder_and_pc_ena),
    .out_pc_reg_ena         (out_pc_reg_ena),
    .out_inst               (out_inst),
    .out_decoder_pc         (out_decoder_pc),
    .out_branch_taken       (out_branch_taken),
    .out_mem_ena            (out_mem_ena),
    .out_address            (out_address),
`ifdef ICACHE_STATS_EN
    .out_hit_count          (out_hit_count),
    .out_miss_count         (out_miss_count),
`endif
    .in_mem_ready           (in_mem_ready),
    .in_mem_inst            (in_mem_inst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: latency 1 answers in the request cycle, latency 3 two cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      req_p1  <= 1'b0;
      req_p2  <= 1'b0;
      addr_p1 <= '0;
      addr_p2 <= '0;
    end else begin
      req_p1  <= out_mem_ena;
      req_p2  <= req_p1;
      addr_p1 <= out_address;
      addr_p2 <= addr_p1;
    end
  end

  always_comb begin
    if (mem_lat == 1) begin
      in_mem_ready = out_mem_ena;
      mem_addr     = out_address;
    end else begin
      in_mem_ready = req_p2;
      mem_addr     = addr_p2;
    end
    in_mem_inst = {16'hC0DE, mem_addr[15:0]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input logic [31:0] base);
    for (int w = 0; w < 4; w++) begin
      chk("fill_req", 32'(out_mem_ena), 32'd1);
      chk("fill_addr", out_address, base + 32'(4 * w));
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; in_rollback = 1'b0;
    in_normal_pc = '0; in_rollback_pc = '0; in_result_taken = 1'b0;
    in_rs_ok = 1'b1; in_rob_ok = 1'b1; in_lsqueue_ok = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_ena", 32'(out_mem_ena), 32'd0);
    chk("rst_addr", out_address, 32'd0);
    chk("rst_dec", 32'(out_decoder_and_pc_ena), 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rst_hits", out_hit_count, 32'd0);
    chk("rst_misses", out_miss_count, 32'd0);
`endif
    rst = 1'b0;

    // Cold miss at 0x0, refill, first hit in cycle 5
    ena = 1'b1; in_normal_pc = 32'h0; #1;
    chk("c0_dec", 32'(out_decoder_and_pc_ena), 32'd0);
    chk("c0_mem", 32'(out_mem_ena), 32'd0);
    next_cycle();
    run_fill(32'h0);
    chk("c5_dec", 32'(out_decoder_and_pc_ena), 32'd1);
    chk("c5_pcreg", 32'(out_pc_reg_ena), 32'd1);
    chk("c5_inst", out_inst, 32'hC0DE0000);
    chk("c5_nomem", 32'(out_mem_ena), 32'd0);
    next_cycle();

    // Sequential hits within the line
    for (int i = 1; i < 4; i++) begin
      in_normal_pc = 32'(4 * i);
      in_result_taken = (i == 2);
      #1;
      chk("hit_dec", 32'(out_decoder_and_pc_ena), 32'd1);
      chk("hit_inst", out_inst, 32'hC0DE0000 + 32'(4 * i));
      chk("hit_pc", out_decoder_pc, 32'(4 * i));
      chk("hit_taken", 32'(out_branch_taken), (i == 2) ? 32'd1 : 32'd0);
      chk("hit_nomem", 32'(out_mem_ena), 32'd0);
      next_cycle();
    end
    in_result_taken = 1'b0;
`ifdef ICACHE_STATS_EN
    chk("stat_hits", out_hit_count, 32'd4);
    chk("stat_misses1", out_miss_count, 32'd1);
`endif

    // Downstream stall on a hit: no issue, no request
    in_normal_pc = 32'h0; in_rob_ok = 1'b0; #1;
    chk("rob_dec", 32'(out_decoder_and_pc_ena), 32'd0);
    chk("rob_pcreg", 32'(out_pc_reg_ena), 32'd0);
    next_cycle();
    chk("rob_nomem", 32'(out_mem_ena), 32'd0);
    in_rob_ok = 1'b1; #1;
    chk("rob_back", 32'(out_decoder_and_pc_ena), 32'd1);
    next_cycle();

    // Rollback while waiting for word 1 with latency-3 memory
    mem_lat = 3; in_normal_pc = 32'h10; #1;
    chk("rb_miss", 32'(out_decoder_and_pc_ena), 32'd0);
    next_cycle();
    chk("rb_req0", 32'(out_mem_ena), 32'd1);
    chk("rb_addr0", out_address, 32'h10);
    next_cycle();
    chk("rb_wait", 32'(out_mem_ena), 32'd0);
    next_cycle();
    next_cycle();
    chk("rb_req1", 32'(out_mem_ena), 32'd1);
    chk("rb_addr1", out_address, 32'h14);
    next_cycle();
    in_rollback = 1'b1; in_rollback_pc = 32'h20; #1;
    chk("rb_dec", 32'(out_decoder_and_pc_ena), 32'd0);
    chk("rb_pc", out_decoder_pc, 32'h20);
    next_cycle();
    in_rollback = 1'b0; in_normal_pc = 32'h20; #1;
    chk("drain_nomem", 32'(out_mem_ena), 32'd0);
    next_cycle();
    chk("idle_nomem", 32'(out_mem_ena), 32'd0);
    next_cycle();
    chk("refill_req", 32'(out_mem_ena), 32'd1);
    chk("refill_addr", out_address, 32'h20);
    n = 0;
    while (out_decoder_and_pc_ena !== 1'b1 && n < 50) begin
      next_cycle();
      n++;
    end
    chk("refill_latency", 32'(n), 32'd12);
    chk("refill_inst", out_inst, 32'hC0DE0020);
    next_cycle();

    ena = 1'b0; in_normal_pc = 32'h10; #1;
    chk("rb_line_invalid", 32'(out_decoder_and_pc_ena), 32'd0);
    next_cycle();
    chk("ena_gate", 32'(out_mem_ena), 32'd0);

    // Rollback coincident with a response
    mem_lat = 1; ena = 1'b1; in_normal_pc = 32'h30; #1;
    chk("co_miss", 32'(out_decoder_and_pc_ena), 32'd0);
    next_cycle();
    in_rollback = 1'b1; in_rollback_pc = 32'h30; #1;
    chk("co_req", 32'(out_mem_ena), 32'd1);
    chk("co_addr", out_address, 32'h30);
    next_cycle();
    in_rollback = 1'b0; #1;
    chk("co_invalid", 32'(out_decoder_and_pc_ena), 32'd0);
    chk("co_nomem", 32'(out_mem_ena), 32'd0);
    next_cycle();
    run_fill(32'h30);
    chk("co_hit", 32'(out_decoder_and_pc_ena), 32'd1);
    chk("co_inst", out_inst, 32'hC0DE0030);

    // Conflict eviction 0x0 vs 0x400, with a hit served mid-fill
    in_normal_pc = 32'h400; #1;
    chk("cf_miss", 32'(out_decoder_and_pc_ena), 32'd0);
    next_cycle();
    run_fill(32'h400);
    chk("cf_hit", 32'(out_decoder_and_pc_ena), 32'd1);
    chk("cf_inst", out_inst, 32'hC0DE0400);
    in_normal_pc = 32'h0; #1;
    chk("cf_evicted", 32'(out_decoder_and_pc_ena), 32'd0);
    next_cycle();
    in_normal_pc = 32'h24; #1;
    chk("fill_hit_dec", 32'(out_decoder_and_pc_ena), 32'd1);
    chk("fill_hit_inst", out_inst, 32'hC0DE0024);
    run_fill(32'h0);
    in_normal_pc = 32'h0; #1;
    chk("cf_refilled", 32'(out_decoder_and_pc_ena), 32'd1);
    chk("cf_refill_inst", out_inst, 32'hC0DE0000);
`ifdef ICACHE_STATS_EN
    chk("stat_misses_end", out_miss_count, 32'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
